// File: rtl/ec_acc_pkg.sv
// Shared definitions for the accumulator datapath controllers:
// input-buffer read FSM encoding and default sizing.
package ec_acc_pkg;

    localparam int unsigned RowsWDefault     = 16;
    localparam int unsigned RdTimeoutDefault = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitVal,
        StPresent,
        StDone
    } inbuf_rd_state_e;

endpackage

// File: rtl/inbuf_rd_ctrl.sv
// Input-buffer read controller: issues one FIFO read at a time, presents each
// row to the multiply units, and counts rows until the stripe is complete.
module inbuf_rd_ctrl
    import ec_acc_pkg::*;
#(
    parameter int unsigned ROWS_W     = RowsWDefault,
    parameter int unsigned RD_TIMEOUT = RdTimeoutDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ROWS_W-1:0] cfg_num_rows,
    input  logic              inbuf_fifo_cntl_empty,
    input  logic              inbuf_dout_reg_val,
    input  logic              mult_rdy,
    output logic              cntl_inbuf_fifo_rd_rq,
    output logic              cntl_inbuf_fifo_mem_en,
    output logic              mult_din_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROWS_W-1:0] rows_done
);

    localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(RD_TIMEOUT - 1);

    inbuf_rd_state_e   state_q, state_d;
    logic [ROWS_W-1:0] num_rows_q, num_rows_d;
    logic [ROWS_W-1:0] rows_done_q, rows_done_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [ROWS_W-1:0] rows_inc;

    assign rows_inc = rows_done_q + ROWS_W'(1);

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        rows_done_d = rows_done_q;
        tmo_d       = tmo_q;
        err_d       = err_q;

        cntl_inbuf_fifo_rd_rq  = 1'b0;
        cntl_inbuf_fifo_mem_en = (state_q != StIdle);
        busy                   = (state_q != StIdle);
        mult_din_val           = (state_q == StPresent);
        done                   = 1'b0;

        // Abort also suppresses a read request and the done pulse in its own cycle.
        if (abort) begin
            state_d = StIdle;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_rows_d  = cfg_num_rows;
                        rows_done_d = '0;
                        err_d       = 1'b0;
                        tmo_d       = '0;
                        state_d     = (cfg_num_rows == '0) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    if (!inbuf_fifo_cntl_empty) begin
                        cntl_inbuf_fifo_rd_rq = 1'b1;
                        tmo_d                 = '0;
                        state_d               = StWaitVal;
                    end
                end
                StWaitVal: begin
                    if (inbuf_dout_reg_val) begin
                        tmo_d   = '0;
                        state_d = StPresent;
                    end else if (tmo_q == TmoLast) begin
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
                StPresent: begin
                    if (mult_rdy) begin
                        rows_done_d = rows_inc;
                        state_d     = (rows_inc == num_rows_q) ? StDone : StIssue;
                    end
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // A stray valid flags an error even if a start clears err in the same cycle.
        if (inbuf_dout_reg_val && (state_q != StWaitVal)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            num_rows_q  <= '0;
            rows_done_q <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            rows_done_q <= rows_done_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    assign err       = err_q;
    assign rows_done = rows_done_q;

endmodule
